// File: rtl/dcm_pkg.sv
// Shared constants and FSM state type for the slow-clock frequency meter.
package dcm_pkg;

    localparam int unsigned MODE_W   = 3;
    localparam int unsigned UNIT_W   = 8;
    localparam int unsigned PRE_W    = 32;
    localparam int unsigned K_W      = UNIT_W + 1;
    localparam int unsigned UNIT_MAX = 128;
    localparam int unsigned UNIT_SAT = 129;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } dcm_state_t;

endpackage : dcm_pkg

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered any-edge detector.
// A transition on d appears as a one-cycle edge_pulse three clk cycles later.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    // Resynchronise d and flag both rising and falling transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync ^ r_prev;
        end
    end

    assign edge_pulse = r_edge;

endmodule : sync_edge

// File: rtl/dcm_freq_meter.sv
// Times consecutive slow_in edges in units of BASE clk cycles, decodes the
// generator mode (interval = 2^mode units), locks after two agreeing
// intervals and flags disagreement with the generator's reported mode.
module dcm_freq_meter
    import dcm_pkg::*;
#(
    parameter int unsigned HALF_MS_CONT = 5000000,
    parameter int unsigned TOL          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slow_in,
    input  logic [MODE_W-1:0] prog_exp,
    output logic [MODE_W-1:0] mode_out,
    output logic              locked,
    output logic              mismatch,
    output logic              err,
    output logic              meas_done
);

    localparam int unsigned BASE = 2 * HALF_MS_CONT;

    logic              w_edge;
    logic              w_timeout;
    logic              w_bad;
    logic              w_good;
    logic [K_W-1:0]    w_k;
    logic [MODE_W-1:0] w_m;

    logic [PRE_W-1:0]  r_pre;
    logic [UNIT_W-1:0] r_units;
    dcm_state_t        r_state;
    logic              r_cand_valid;
    logic [MODE_W-1:0] r_cand;
    logic [MODE_W-1:0] r_mode;
    logic              r_locked;
    logic              r_mismatch;
    logic              r_err;
    logic              r_meas_done;

    sync_edge u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .d          (slow_in),
        .edge_pulse (w_edge)
    );

    // Interval counters; the edge cycle itself counts as the first cycle so
    // the value held at the next edge equals the interval length
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_units <= '0;
        end else if (w_edge) begin
            r_pre   <= PRE_W'(1);
            r_units <= '0;
        end else if (r_state == SEEK) begin
            r_pre   <= '0;
            r_units <= '0;
        end else if (r_pre == PRE_W'(BASE - 1)) begin
            r_pre   <= '0;
            r_units <= (r_units == UNIT_W'(UNIT_SAT)) ? r_units
                                                      : r_units + UNIT_W'(1);
        end else begin
            r_pre   <= r_pre + PRE_W'(1);
        end
    end

    // Round the interval to whole units and decode a power-of-two mode
    always_comb begin
        w_k    = '0;
        w_bad  = 1'b1;
        w_good = 1'b0;
        w_m    = '0;
        if (r_pre <= PRE_W'(TOL)) begin
            w_k   = {1'b0, r_units};
            w_bad = 1'b0;
        end else if (r_pre >= PRE_W'(BASE - TOL)) begin
            w_k   = {1'b0, r_units} + K_W'(1);
            w_bad = 1'b0;
        end
        for (int i = 0; i < (2 ** MODE_W); i++) begin
            if (w_k == K_W'(1 << i)) begin
                w_good = !w_bad;
                w_m    = MODE_W'(i);
            end
        end
    end

    // Timeout is the cycle units would step to the saturation value; an edge
    // arriving in that same cycle is evaluated instead
    assign w_timeout = !w_edge && (r_state != SEEK) &&
                       (r_units == UNIT_W'(UNIT_MAX)) &&
                       (r_pre == PRE_W'(BASE - 1));

    // Lock FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEEK;
            r_cand_valid <= 1'b0;
            r_cand       <= '0;
            r_mode       <= '0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_meas_done  <= 1'b0;
        end else begin
            r_meas_done <= 1'b0;
            case (r_state)
                SEEK: begin
                    if (w_edge) begin
                        r_state      <= MEASURE;
                        r_cand_valid <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_edge) begin
                        r_meas_done <= 1'b1;
                        if (w_good && r_cand_valid && (w_m == r_cand)) begin
                            r_state  <= LOCKED;
                            r_mode   <= w_m;
                            r_locked <= 1'b1;
                            r_err    <= 1'b0;
                        end else if (w_good) begin
                            r_cand       <= w_m;
                            r_cand_valid <= 1'b1;
                        end else begin
                            r_cand_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= SEEK;
                        r_locked     <= 1'b0;
                        r_err        <= 1'b1;
                        r_cand_valid <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (w_edge) begin
                        r_meas_done <= 1'b1;
                        if (w_good && (w_m != r_mode)) begin
                            r_state      <= MEASURE;
                            r_cand       <= w_m;
                            r_cand_valid <= 1'b1;
                            r_locked     <= 1'b0;
                        end else if (!w_good) begin
                            r_state      <= MEASURE;
                            r_cand_valid <= 1'b0;
                            r_locked     <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= SEEK;
                        r_locked     <= 1'b0;
                        r_err        <= 1'b1;
                        r_cand_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= SEEK;
                    r_locked     <= 1'b0;
                    r_cand_valid <= 1'b0;
                end
            endcase
        end
    end

    // Compare the locked mode against the generator's reported mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= r_locked && (r_mode != prog_exp);
        end
    end

    assign mode_out  = r_mode;
    assign locked    = r_locked;
    assign mismatch  = r_mismatch;
    assign err       = r_err;
    assign meas_done = r_meas_done;

endmodule : dcm_freq_meter

// File: tb/tb_dcm_freq_meter.sv
// Directed bench for dcm_freq_meter with BASE=10, TOL=2.
module tb_dcm_freq_meter;

    logic       clk;
    logic       rst;
    logic       slow_in;
    logic [2:0] prog_exp;
    logic [2:0] mode_out;
    logic       locked;
    logic       mismatch;
    logic       err;
    logic       meas_done;

    int n_checks = 0;
    int n_fail   = 0;
    int md_cnt   = 0;
    int lock_cnt = 0;
    int md0;
    int lk0;

    dcm_freq_meter #(
        .HALF_MS_CONT (5),
        .TOL          (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slow_in   (slow_in),
        .prog_exp  (prog_exp),
        .mode_out  (mode_out),
        .locked    (locked),
        .mismatch  (mismatch),
        .err       (err),
        .meas_done (meas_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tallies of evaluation pulses and locked cycles
    always @(negedge clk) begin
        if (meas_done) md_cnt++;
        if (locked) lock_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] p);
        rst      = 1'b1;
        slow_in  = 1'b0;
        prog_exp = p;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Toggle slow_in, then wait h cycles
    task automatic edge_wait(input int h);
        slow_in = ~slow_in;
        repeat (h) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        slow_in  = 1'b0;
        prog_exp = 3'd0;
        @(negedge clk);

        // Reset state and lock on 40-cycle half-periods
        do_reset(3'd2);
        chk("rst_mode", 32'(mode_out), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_meas_done", 32'(meas_done), 0);
        edge_wait(40);
        edge_wait(40);
        edge_wait(3);
        chk("A_prelock", 32'(locked), 0);
        @(negedge clk);
        chk("A_locked", 32'(locked), 1);
        chk("A_mode", 32'(mode_out), 2);
        chk("A_meas_done", 32'(meas_done), 1);
        @(negedge clk);
        chk("A_mismatch", 32'(mismatch), 0);
        chk("A_meas_done_pulse", 32'(meas_done), 0);

        // Mismatch against a wrong reported mode, then cleared
        do_reset(3'd5);
        edge_wait(40);
        edge_wait(40);
        edge_wait(4);
        chk("B_locked", 32'(locked), 1);
        chk("B_mismatch_lag", 32'(mismatch), 0);
        @(negedge clk);
        chk("B_mismatch", 32'(mismatch), 1);
        prog_exp = 3'd2;
        @(negedge clk);
        chk("B_mismatch_clr", 32'(mismatch), 0);

        // Lock at mode 0, switch to mode 3
        do_reset(3'd0);
        edge_wait(10);
        edge_wait(10);
        edge_wait(10);
        chk("C_lock0", 32'(locked), 1);
        chk("C_mode0", 32'(mode_out), 0);
        edge_wait(80);
        edge_wait(4);
        chk("C_drop", 32'(locked), 0);
        chk("C_mode_hold", 32'(mode_out), 0);
        repeat (76) @(negedge clk);
        edge_wait(4);
        chk("C_relock", 32'(locked), 1);
        chk("C_mode3", 32'(mode_out), 3);
        @(negedge clk);
        chk("C_mismatch", 32'(mismatch), 1);

        // Off-grid 15-cycle half-periods never lock
        do_reset(3'd0);
        md0 = md_cnt;
        lk0 = lock_cnt;
        repeat (6) edge_wait(15);
        chk("D_meas_cnt", 32'(md_cnt - md0), 5);
        chk("D_never_locked", 32'(lock_cnt - lk0), 0);

        // Tolerance: 38 and 42 lock, 36 is bad
        do_reset(3'd2);
        edge_wait(38);
        edge_wait(42);
        edge_wait(4);
        chk("E_lock_tol", 32'(locked), 1);
        chk("E_mode_tol", 32'(mode_out), 2);
        repeat (32) @(negedge clk);
        edge_wait(4);
        chk("E_bad36", 32'(locked), 0);
        chk("E_bad36_done", 32'(meas_done), 1);
        chk("E_bad36_mode", 32'(mode_out), 2);

        // Timeout after lock, then reset mid-interval
        do_reset(3'd2);
        edge_wait(40);
        edge_wait(40);
        edge_wait(4);
        chk("F_locked", 32'(locked), 1);
        repeat (1288) @(negedge clk);
        chk("F_err_before", 32'(err), 0);
        chk("F_locked_before", 32'(locked), 1);
        @(negedge clk);
        chk("F_err", 32'(err), 1);
        chk("F_unlock", 32'(locked), 0);
        chk("F_mode_hold", 32'(mode_out), 2);
        edge_wait(20);
        chk("F_err_sticky", 32'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("F_rst_mode", 32'(mode_out), 0);
        chk("F_rst_locked", 32'(locked), 0);
        chk("F_rst_err", 32'(err), 0);
        chk("F_rst_mismatch", 32'(mismatch), 0);
        chk("F_rst_meas_done", 32'(meas_done), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dcm_freq_meter

// File: doc/dcm_freq_meter.md
# dcm_freq_meter

Measures the slow clock produced by the programmable clock generator and decodes which of its eight modes it is running in. It sits on the consumer side of the generator's slow clock and mode-report interface. It samples the slow clock as data in the 100 MHz domain and times consecutive edges against the same base period the generator uses. It reports a locked mode and flags disagreement with the generator's reported mode.

## Interface
- HALF_MS_CONT, 5000000, base half-period in clk cycles; BASE = 2*HALF_MS_CONT clk cycles is one unit
- TOL, 2, allowed deviation in clk cycles of an interval from a whole number of units
- clk  in  1  100 MHz reference clock; the only clock
- rst  in  1  synchronous, active-high reset
- slow_in  in  1  slow clock under measurement, sampled as data
- prog_exp  in  3  mode the generator reports it is producing
- mode_out  out  3  last locked mode; reset 0
- locked  out  1  two consecutive matching good intervals seen; reset 0
- mismatch  out  1  locked && mode_out != prog_exp, registered; reset 0
- err  out  1  sticky timeout flag; cleared on the next lock; reset 0
- meas_done  out  1  one-cycle pulse per evaluated interval; reset 0

## Operation
- slow_in passes through a 2-flop synchroniser and an edge register. Both edges produce one-cycle `edge` pulses.
- Counters:
  - pre: 32 bit, 0..BASE-1; wraps and increments `units`.
  - units: 8 bit, saturating at 129.
  - Both counters clear to 0 on every `edge`.
- Evaluation on `edge`, using the values held just before the clear, gives the interval N = units*BASE + pre:
  - pre <= TOL → k = units
  - else pre >= BASE-TOL → k = units+1
  - else bad
  - good iff not bad and k ∈ {1,2,4,…,128}; then candidate mode m = log2(k).
- FSM states SEEK, MEASURE, LOCKED:
  - SEEK: counters idle. The first `edge` starts counting → MEASURE with no candidate. No evaluation and no meas_done.
  - MEASURE:
    - good and m equals the stored candidate → LOCKED; mode_out ← m, locked ← 1, err ← 0.
    - good and no candidate or a different candidate → store m, stay.
    - bad → clear the candidate, stay.
  - LOCKED:
    - good and m == mode_out → stay.
    - good and m != mode_out → MEASURE with candidate m; locked ← 0; mode_out holds.
    - bad → MEASURE with no candidate; locked ← 0.
  - Any state other than SEEK: units reaching 129 without an edge is a timeout → SEEK; locked ← 0, err ← 1, candidate cleared.
- meas_done pulses on each evaluation made in MEASURE or LOCKED.
- A generator mode switch mid-interval yields a bad or mismatched interval. This drops the lock for at least two intervals by design.

## Timing
- slow_in transition to `edge` takes 3 clk cycles. The latency is constant, so interval lengths are unaffected.
- locked, mode_out, err and meas_done update in the cycle after `edge` (registered).
- mismatch is registered from the current locked, mode_out and prog_exp. It lags a prog_exp change by 1 cycle.
- Minimum time to lock after reset: first edge plus two full half-periods, plus 4 cycles.
- rst asserted at any cycle forces all outputs and counters to their reset values and the FSM to SEEK on the next clk edge.
- An edge coinciding with the timeout cycle: the edge wins. It is evaluated normally because units is still 128 when sampled.

## Structure
- Package dcm_pkg holds:
  - MODE_W = 3
  - UNIT_MAX = 128
  - UNIT_SAT = 129
  - the FSM state typedef (SEEK, MEASURE, LOCKED)
- One sub-module, sync_edge: 2-flop synchroniser plus edge detector. Ports: clk, rst, d, edge.
- Power-of-two decode and log2 are combinational inside dcm_freq_meter.

## Test plan
Sim settings: HALF_MS_CONT=5 (BASE=10), TOL=2.
- Square wave with half-period 40 cycles, prog_exp=2 → locked=1, mode_out=2 after the third edge+1; mismatch=0.
- Same stimulus, prog_exp=5 → mismatch=1 one cycle after locked rises; changing prog_exp to 2 → mismatch=0 next cycle.
- Lock at half-period 10, then switch to 80 → locked drops at the first 80-cycle evaluation and mode_out stays 0. Re-lock after the second 80 interval gives mode_out=3.
- Half-periods of 15 cycles → every evaluation is bad; meas_done pulses; locked stays 0.
- Half-periods of 38 and 42 (within TOL) → locks at mode 2; 36 → bad.
- slow_in held constant after lock → err=1 and locked=0 when units reaches 129 (1290 cycles). Then rst mid-interval → all outputs 0 in the following cycle.
